// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg
// Shared definitions for the CP0 exception unit: CP0 register numbers,
// exception codes, the exception handler entry address, the PRId value and
// the packed layouts of the architecturally visible SR and Cause bits.
//
// Optional feature macro used by the importing design: CP0_COUNT_EN
// (enables the Count register at register number 9).
// -----------------------------------------------------------------------------
package cp0_pkg;

    // CP0 register numbers as seen by mtc0/mfc0
    localparam logic [4:0] CP0_REG_COUNT = 5'd9;
    localparam logic [4:0] CP0_REG_SR    = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
    localparam logic [4:0] CP0_REG_EPC   = 5'd14;
    localparam logic [4:0] CP0_REG_PRID  = 5'd15;

    // Exception codes carried in Cause.ExcCode
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Fetch redirect target when req is raised
    localparam logic [31:0] CP0_HANDLER_ADDR = 32'h0000_4180;

    // Processor identification, read-only
    localparam logic [31:0] CP0_PRID_VALUE = 32'h2023_0007;

    // Status register: only the implemented fields are stored
    typedef struct packed {
        logic [5:0] im;    // interrupt mask, SR[15:10]
        logic       exl;   // exception level, SR[1]
        logic       ie;    // global interrupt enable, SR[0]
    } sr_t;

    // Cause register: only the implemented fields are stored
    typedef struct packed {
        logic       bd;    // branch delay, Cause[31]
        logic [5:0] ip;    // pending hardware interrupts, Cause[15:10]
        logic [4:0] exc;   // exception code, Cause[6:2]
    } cause_t;

    // Place the stored SR fields at their architectural bit positions
    function automatic logic [31:0] sr_to_word(input sr_t s);
        logic [31:0] w;
        w        = 32'h0;
        w[15:10] = s.im;
        w[1]     = s.exl;
        w[0]     = s.ie;
        return w;
    endfunction

    // Place the stored Cause fields at their architectural bit positions
    function automatic logic [31:0] cause_to_word(input cause_t c);
        logic [31:0] w;
        w        = 32'h0;
        w[31]    = c.bd;
        w[15:10] = c.ip;
        w[6:2]   = c.exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0_exc_unit.sv
// -----------------------------------------------------------------------------
// cp0_exc_unit
// Coprocessor-0 exception/interrupt unit sitting beside the M stage.
// Holds SR, Cause, EPC (and optionally Count), decides whether the M-stage
// instruction takes an exception or interrupt, and supplies mfc0 read data
// and the eret return address.
//
// Ports
//   clk          in   1   clock
//   reset        in   1   synchronous active-high reset
//   en           in   1   mtc0 write strobe from M stage
//   addr         in   5   CP0 register number for mtc0/mfc0
//   wdata        in  32   mtc0 write data
//   rdata        out 32   mfc0 read data (combinational, pre-write state)
//   vpc          in  32   PC of the M-stage instruction
//   bd_in        in   1   M-stage instruction is in a branch delay slot
//   exc_code_in  in   5   M-stage exception code, 0 = none
//   hw_int       in   6   level-sensitive hardware interrupt lines
//   is_eret      in   1   M-stage instruction is eret
//   epc_out      out 32   eret return address (bypasses a same-cycle EPC mtc0)
//   req          out  1   exception/interrupt taken this cycle
//
// Configuration
//   CP0_COUNT_EN  when defined, register 9 is a free-running 32-bit Count
//                 register writable by mtc0; otherwise it reads 0 and no
//                 counter state exists.
// -----------------------------------------------------------------------------
module cp0_exc_unit
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        is_eret,
    output logic [31:0] epc_out,
    output logic        req
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    sr_t         sr_q,    sr_d;
    cause_t      cause_q, cause_d;
    logic [29:0] epc_q,   epc_d;     // EPC[31:2]; EPC[1:0] are always 0

`ifdef CP0_COUNT_EN
    logic [31:0] count_q, count_d;
`endif

    // vpc is word aligned; its low bits never reach EPC
    logic unused_vpc_lo;
    assign unused_vpc_lo = ^vpc[1:0];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic int_req;
    logic exc_req;
    logic mtc0_ok;

    // EXL masks both sources, so a handler is never re-entered
    assign int_req = (|(hw_int & sr_q.im)) & sr_q.ie & ~sr_q.exl;
    assign exc_req = (exc_code_in != 5'd0) & ~sr_q.exl;

    // Reset forces req low even though state is only cleared at the edge
    assign req     = (int_req | exc_req) & ~reset;

    // A taken exception squashes the M-stage instruction, including mtc0
    assign mtc0_ok = en & ~req;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        sr_d    = sr_q;
        cause_d = cause_q;
        epc_d   = epc_q;

        // IP tracks the interrupt lines unconditionally
        cause_d.ip = hw_int;

        if (req) begin
            sr_d.exl    = 1'b1;
            // Interrupt wins over a simultaneous synchronous exception
            cause_d.exc = int_req ? 5'(EXC_INT) : exc_code_in;
            cause_d.bd  = bd_in;
            // Delay-slot victims restart at the branch (word index - 1)
            epc_d       = bd_in ? (vpc[31:2] - 30'd1) : vpc[31:2];
        end else begin
            if (mtc0_ok) begin
                case (addr)
                    CP0_REG_SR: begin
                        sr_d.im  = wdata[15:10];
                        sr_d.exl = wdata[1];
                        sr_d.ie  = wdata[0];
                    end
                    CP0_REG_EPC: epc_d = wdata[31:2];
                    default: ;
                endcase
            end
            // Applied after mtc0 so an eret always leaves exception level
            if (is_eret) begin
                sr_d.exl = 1'b0;
            end
        end
    end

`ifdef CP0_COUNT_EN
    // A software write replaces this cycle's increment
    always_comb begin
        count_d = count_q + 32'd1;
        if (mtc0_ok && (addr == CP0_REG_COUNT)) begin
            count_d = wdata;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

`ifdef CP0_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read paths
    // ------------------------------------------------------------------
    // mfc0 sees the registered state only; no write-through
    always_comb begin
        rdata = 32'h0;
        case (addr)
`ifdef CP0_COUNT_EN
            CP0_REG_COUNT: rdata = count_q;
`endif
            CP0_REG_SR:    rdata = sr_to_word(sr_q);
            CP0_REG_CAUSE: rdata = cause_to_word(cause_q);
            CP0_REG_EPC:   rdata = {epc_q, 2'b00};
            CP0_REG_PRID:  rdata = CP0_PRID_VALUE;
            default:       rdata = 32'h0;
        endcase
    end

    // eret directly after mtc0 EPC must already see the new value
    always_comb begin
        epc_out = {epc_q, 2'b00};
        if (en && (addr == CP0_REG_EPC)) begin
            epc_out = {wdata[31:2], 2'b00};
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit. Each stimulus cycle pushes the values
// expected on req / rdata / epc_out for that cycle into a scoreboard; a
// monitor on the falling edge pops and compares them against the DUT.
module tb_cp0_exc_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        is_eret;
    logic [31:0] epc_out;
    logic        req;

    cp0_exc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .is_eret     (is_eret),
        .epc_out     (epc_out),
        .req         (req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int SEL_REQ = 0;
    localparam int SEL_RD  = 1;
    localparam int SEL_EPC = 2;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation registered for the current cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.sel)
                SEL_REQ: act = {31'b0, req};
                SEL_RD:  act = rdata;
                default: act = epc_out;
            endcase
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
    end

    task automatic idle();
        reset = 1'b0; en = 1'b0; addr = 5'd0; wdata = 32'h0; vpc = 32'h0;
        bd_in = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; is_eret = 1'b0;
    endtask

    task automatic expect_v(input string nm, input int sel, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] cnt_a, cnt_b, cnt_c;

    initial begin
        idle();
        reset = 1'b1;
        tick();

        // Reset cycle: an exception code must not raise req
        idle(); reset = 1'b1; exc_code_in = 5'd12;
        expect_v("req_in_reset", SEL_REQ, 32'd0);
        tick();

        idle(); addr = 5'd12;
        expect_v("sr_after_reset", SEL_RD, 32'h0);
        expect_v("epc_out_after_reset", SEL_EPC, 32'h0);
        tick();
        idle(); addr = 5'd15;
        expect_v("prid", SEL_RD, 32'h2023_0007);
        tick();
        idle(); addr = 5'd7;
        expect_v("unmapped_reads_0", SEL_RD, 32'h0);
        tick();

        // Interrupt path: enable IM[0] and IE
        idle(); en = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
        expect_v("sr_old_during_write", SEL_RD, 32'h0);
        expect_v("req_idle", SEL_REQ, 32'd0);
        tick();
        idle(); hw_int = 6'b000001; vpc = 32'h0000_1000; addr = 5'd12;
        expect_v("sr_written", SEL_RD, 32'h0000_0401);
        expect_v("int_req", SEL_REQ, 32'd1);
        tick();
        idle(); hw_int = 6'b000001; addr = 5'd13;
        expect_v("cause_after_int", SEL_RD, 32'h0000_0400);
        expect_v("req_masked_exl", SEL_REQ, 32'd0);
        expect_v("epc_out_after_int", SEL_EPC, 32'h0000_1000);
        tick();
        idle(); addr = 5'd12;
        expect_v("sr_exl_set", SEL_RD, 32'h0000_0403);
        tick();
        idle(); addr = 5'd14; is_eret = 1'b1;
        expect_v("epc_after_int", SEL_RD, 32'h0000_1000);
        expect_v("req_on_eret", SEL_REQ, 32'd0);
        tick();

        // Synchronous exception in a delay slot
        idle(); exc_code_in = 5'd12; bd_in = 1'b1; vpc = 32'h0000_3010; addr = 5'd13;
        expect_v("cause_before_exc", SEL_RD, 32'h0);
        expect_v("exc_req", SEL_REQ, 32'd1);
        tick();
        idle(); exc_code_in = 5'd12; addr = 5'd13;
        expect_v("cause_ov_bd", SEL_RD, 32'h8000_0030);
        expect_v("exc_masked_exl", SEL_REQ, 32'd0);
        expect_v("epc_out_bd", SEL_EPC, 32'h0000_300C);
        tick();
        idle(); exc_code_in = 5'd4; addr = 5'd14;
        expect_v("epc_bd", SEL_RD, 32'h0000_300C);
        expect_v("adel_masked", SEL_REQ, 32'd0);
        tick();

        // eret with a pending exception: req follows on the next cycle
        idle(); exc_code_in = 5'd4; is_eret = 1'b1; addr = 5'd12;
        expect_v("sr_before_eret", SEL_RD, 32'h0000_0403);
        expect_v("eret_no_req", SEL_REQ, 32'd0);
        tick();
        idle(); exc_code_in = 5'd4; vpc = 32'h0000_2000; addr = 5'd12;
        expect_v("sr_after_eret", SEL_RD, 32'h0000_0401);
        expect_v("pending_exc_req", SEL_REQ, 32'd1);
        tick();
        idle(); addr = 5'd13;
        expect_v("cause_adel", SEL_RD, 32'h0000_0010);
        tick();

        // EPC write bypass to epc_out, rdata keeps the old value
        idle(); en = 1'b1; addr = 5'd14; wdata = 32'h0000_3007;
        expect_v("epc_bypass", SEL_EPC, 32'h0000_3004);
        expect_v("epc_rd_old", SEL_RD, 32'h0000_2000);
        tick();
        idle(); addr = 5'd14;
        expect_v("epc_rd_new", SEL_RD, 32'h0000_3004);
        expect_v("epc_out_new", SEL_EPC, 32'h0000_3004);
        tick();
        idle(); is_eret = 1'b1; addr = 5'd12;
        expect_v("sr_before_eret2", SEL_RD, 32'h0000_0403);
        tick();

        // Interrupt + exception + SR write together: interrupt wins, write lost
        idle(); hw_int = 6'b000001; exc_code_in = 5'd5; bd_in = 1'b1;
        vpc = 32'h0000_5008; en = 1'b1; addr = 5'd12; wdata = 32'h0;
        expect_v("prio_req", SEL_REQ, 32'd1);
        expect_v("prio_epc_out_no_bypass", SEL_EPC, 32'h0000_3004);
        tick();
        idle(); addr = 5'd12;
        expect_v("sr_write_discarded", SEL_RD, 32'h0000_0403);
        tick();
        idle(); addr = 5'd13;
        expect_v("cause_int_prio", SEL_RD, 32'h8000_0000);
        tick();
        idle(); addr = 5'd14;
        expect_v("epc_int_prio", SEL_RD, 32'h0000_5004);
        tick();

        // Cause is read-only to mtc0
        idle(); en = 1'b1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
        tick();
        idle(); addr = 5'd13;
        expect_v("cause_not_writable", SEL_RD, 32'h8000_0000);
        tick();

        // Reset mid-handler overrides a concurrent mtc0 and eret
        idle(); reset = 1'b1; en = 1'b1; addr = 5'd14; wdata = 32'h0000_1234;
        is_eret = 1'b1; exc_code_in = 5'd10;
        expect_v("req_in_reset_mid", SEL_REQ, 32'd0);
        tick();
        idle(); addr = 5'd12;
        expect_v("sr_reset_mid", SEL_RD, 32'h0);
        tick();
        idle(); addr = 5'd13;
        expect_v("cause_reset_mid", SEL_RD, 32'h0);
        tick();
        idle(); addr = 5'd14;
        expect_v("epc_reset_mid", SEL_RD, 32'h0);
        tick();

        // Count register
`ifdef CP0_COUNT_EN
        cnt_a = 32'hFFFF_FFFE; cnt_b = 32'hFFFF_FFFF; cnt_c = 32'h0;
`else
        cnt_a = 32'h0; cnt_b = 32'h0; cnt_c = 32'h0;
`endif
        idle(); en = 1'b1; addr = 5'd9; wdata = 32'hFFFF_FFFE;
        tick();
        idle(); addr = 5'd9;
        expect_v("count_0", SEL_RD, cnt_a);
        tick();
        idle(); addr = 5'd9;
        expect_v("count_1", SEL_RD, cnt_b);
        tick();
        idle(); addr = 5'd9;
        expect_v("count_wrap", SEL_RD, cnt_c);
        tick();

        idle();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the stimulus never completes
    initial begin
        #100000;
        $display("FAIL timeout: stimulus did not complete");
        $fatal(1, "timeout");
    end

endmodule
